// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register-file writeback scheduler with hazard scoreboard
//
// Purpose:
//   Owns the single shared write port of the integer/FP register file pair.
//   A 64-entry scoreboard (32 int + 32 FP busy bits) records destinations of
//   issued-but-not-written instructions and stalls decode on RAW/WAW hazards.
//   NREQ writeback sources are round-robin arbitrated onto a registered
//   write port (wb_add/wb_data/is_wb_data_fp/write_reg).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   issue_*               decode-stage instruction descriptor
//   stall                 combinational issue block
//   req_valid/add/data/fp per-requester writeback (slice i), req_ready one-hot grant
//   wb_add, wb_data       registered register-file write address/data
//   write_reg             registered register-file write enable
//   is_wb_data_fp         registered FP/int file select

module regfile_wb_scheduler #(
    parameter int NREQ  = 3,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_writes_rd,
    input  logic [4:0]        issue_rd_add,
    input  logic              issue_rd_fp,
    input  logic [4:0]        issue_rs1_add,
    input  logic              issue_rs1_fp,
    input  logic [4:0]        issue_rs2_add,
    input  logic              issue_rs2_fp,
    input  logic              issue_uses_rs3,
    input  logic [4:0]        issue_rs3_add,
    output logic              stall,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [5*NREQ-1:0] req_add,
    input  logic [32*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_fp,
    output logic [NREQ-1:0]   req_ready,
    output logic [4:0]        wb_add,
    output logic [31:0]       wb_data,
    output logic              write_reg,
    output logic              is_wb_data_fp
);

    logic [31:0]      busy_int_q, busy_int_d;
    logic [31:0]      busy_fp_q, busy_fp_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [4:0]       wb_add_q, wb_add_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             write_reg_q, write_reg_d;
    logic             wb_fp_q, wb_fp_d;

    logic             rs1_busy, rs2_busy, rs3_busy, rd_busy;
    logic             xfer;
    logic [PTR_W-1:0] grant_idx;
    logic [4:0]       sel_add;
    logic [31:0]      sel_data;
    logic             sel_fp;

    // Hazard detection against the scoreboard
    always_comb begin
        rs1_busy = issue_rs1_fp ? busy_fp_q[issue_rs1_add] : busy_int_q[issue_rs1_add];
        rs2_busy = issue_rs2_fp ? busy_fp_q[issue_rs2_add] : busy_int_q[issue_rs2_add];
        rs3_busy = issue_uses_rs3 & busy_fp_q[issue_rs3_add];
        rd_busy  = issue_writes_rd & (issue_rd_fp ? busy_fp_q[issue_rd_add]
                                                  : busy_int_q[issue_rd_add]);
        stall    = issue_valid & (rs1_busy | rs2_busy | rs3_busy | rd_busy);
    end

    // Round-robin grant: first valid index at or after rr_ptr, wrapping
    always_comb begin
        int cand;
        xfer      = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        sel_add   = '0;
        sel_data  = '0;
        sel_fp    = 1'b0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!xfer && req_valid[cand]) begin
                xfer      = 1'b1;
                grant_idx = PTR_W'(cand);
            end
        end
        if (xfer) begin
            req_ready[grant_idx] = 1'b1;
        end
        // req_ready is one-hot, so a plain OR-mux selects the granted slice
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_add  = req_add[i*5 +: 5];
                sel_data = req_data[i*32 +: 32];
                sel_fp   = req_fp[i];
            end
        end
    end

    // Next state: pointer, output register, scoreboard
    always_comb begin
        int nxt;
        nxt         = 0;
        rr_ptr_d    = rr_ptr_q;
        write_reg_d = xfer;
        wb_add_d    = wb_add_q;
        wb_data_d   = wb_data_q;
        wb_fp_d     = wb_fp_q;
        busy_int_d  = busy_int_q;
        busy_fp_d   = busy_fp_q;

        if (xfer) begin
            nxt = int'(grant_idx) + 1;
            if (nxt >= NREQ) begin
                nxt = 0;
            end
            rr_ptr_d  = PTR_W'(nxt);
            wb_add_d  = sel_add;
            wb_data_d = sel_data;
            wb_fp_d   = sel_fp;
        end

        // Clear at the edge ending the write cycle; the file committed on the
        // preceding negedge, so a dependent reader sees the new value.
        if (write_reg_q) begin
            if (wb_fp_q) begin
                busy_fp_d[wb_add_q] = 1'b0;
            end else begin
                busy_int_d[wb_add_q] = 1'b0;
            end
        end

        // Set is applied after clear so it wins on a same-bit collision
        if (issue_valid && !stall && issue_writes_rd) begin
            if (issue_rd_fp) begin
                busy_fp_d[issue_rd_add] = 1'b1;
            end else begin
                busy_int_d[issue_rd_add] = 1'b1;
            end
        end

        busy_int_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_int_q  <= '0;
            busy_fp_q   <= '0;
            rr_ptr_q    <= '0;
            wb_add_q    <= '0;
            wb_data_q   <= '0;
            write_reg_q <= 1'b0;
            wb_fp_q     <= 1'b0;
        end else begin
            busy_int_q  <= busy_int_d;
            busy_fp_q   <= busy_fp_d;
            rr_ptr_q    <= rr_ptr_d;
            wb_add_q    <= wb_add_d;
            wb_data_q   <= wb_data_d;
            write_reg_q <= write_reg_d;
            wb_fp_q     <= wb_fp_d;
        end
    end

    assign wb_add        = wb_add_q;
    assign wb_data       = wb_data_q;
    assign write_reg     = write_reg_q;
    assign is_wb_data_fp = wb_fp_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard testbench for regfile_wb_scheduler

module tb_regfile_wb_scheduler;

    localparam int NREQ = 3;

    typedef struct {
        logic [4:0]  add;
        logic [31:0] data;
        logic        fp;
    } wb_t;

    logic              clk;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_writes_rd;
    logic [4:0]        issue_rd_add;
    logic              issue_rd_fp;
    logic [4:0]        issue_rs1_add;
    logic              issue_rs1_fp;
    logic [4:0]        issue_rs2_add;
    logic              issue_rs2_fp;
    logic              issue_uses_rs3;
    logic [4:0]        issue_rs3_add;
    logic              stall;
    logic [NREQ-1:0]   req_valid;
    logic [5*NREQ-1:0] req_add;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_fp;
    logic [NREQ-1:0]   req_ready;
    logic [4:0]        wb_add;
    logic [31:0]       wb_data;
    logic              write_reg;
    logic              is_wb_data_fp;

    int n_checks = 0;
    int n_fail   = 0;
    wb_t exp_q[$];
    logic [31:0] rf_int [32];
    logic [31:0] rf_fp  [32];

    regfile_wb_scheduler #(.NREQ(NREQ)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_valid     (issue_valid),
        .issue_writes_rd (issue_writes_rd),
        .issue_rd_add    (issue_rd_add),
        .issue_rd_fp     (issue_rd_fp),
        .issue_rs1_add   (issue_rs1_add),
        .issue_rs1_fp    (issue_rs1_fp),
        .issue_rs2_add   (issue_rs2_add),
        .issue_rs2_fp    (issue_rs2_fp),
        .issue_uses_rs3  (issue_uses_rs3),
        .issue_rs3_add   (issue_rs3_add),
        .stall           (stall),
        .req_valid       (req_valid),
        .req_add         (req_add),
        .req_data        (req_data),
        .req_fp          (req_fp),
        .req_ready       (req_ready),
        .wb_add          (wb_add),
        .wb_data         (wb_data),
        .write_reg       (write_reg),
        .is_wb_data_fp   (is_wb_data_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic wrd, input logic [4:0] rd, input logic rdfp,
                             input logic [4:0] rs1, input logic rs1fp, input logic u3,
                             input logic [4:0] rs3);
        issue_valid     = v;
        issue_writes_rd = wrd;
        issue_rd_add    = rd;
        issue_rd_fp     = rdfp;
        issue_rs1_add   = rs1;
        issue_rs1_fp    = rs1fp;
        issue_rs2_add   = 5'd0;
        issue_rs2_fp    = 1'b0;
        issue_uses_rs3  = u3;
        issue_rs3_add   = rs3;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d, input logic f);
        req_add[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
        req_fp[i]           = f;
    endtask

    // Present a valid mask, check the hand-computed grant, queue the expected write
    task automatic grant(input logic [2:0] valid, input logic [2:0] exp_ready, input int exp_idx,
                         input bit push);
        wb_t e;
        req_valid = valid;
        #1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (push) begin
            e.add  = req_add[exp_idx*5 +: 5];
            e.data = req_data[exp_idx*32 +: 32];
            e.fp   = req_fp[exp_idx];
            exp_q.push_back(e);
        end
        step();
    endtask

    // Monitor / register-file model: commit on the negedge of each write cycle
    always @(negedge clk) begin
        wb_t e;
        if (rst_n && write_reg) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got add %h data %h fp %b, none expected",
                         wb_add, wb_data, is_wb_data_fp);
            end else begin
                e = exp_q.pop_front();
                check("wb_add", 32'(wb_add), 32'(e.add));
                check("wb_data", wb_data, e.data);
                check("is_wb_data_fp", 32'(is_wb_data_fp), 32'(e.fp));
            end
            if (is_wb_data_fp) rf_fp[wb_add] = wb_data;
            else if (wb_add != 5'd0) rf_int[wb_add] = wb_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_int[i] = '0;
            rf_fp[i]  = '0;
        end
        rst_n     = 1'b0;
        req_valid = '0;
        req_add   = '0;
        req_data  = '0;
        req_fp    = '0;
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_wb_add", 32'(wb_add), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_fp", 32'(is_wb_data_fp), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        step();

        // RAW on x5
        set_issue(1, 1, 5'd5, 0, 5'd0, 0, 0, 0);
        #1 check("raw_first_issue_stall", 32'(stall), 32'd0);
        step();
        set_issue(1, 0, 5'd0, 0, 5'd5, 0, 0, 0);
        #1 check("raw_stall", 32'(stall), 32'd1);
        set_req(0, 5'd5, 32'hDEADBEEF, 1'b0);
        grant(3'b001, 3'b001, 0, 1);
        req_valid = '0;
        #1 check("raw_stall_write_cycle", 32'(stall), 32'd1);
        check("raw_write_reg", 32'(write_reg), 32'd1);
        step();
        check("raw_stall_released", 32'(stall), 32'd0);
        check("raw_rf_x5", rf_int[5], 32'hDEADBEEF);
        step();
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);

        // FP / int separation on index 5
        set_issue(1, 1, 5'd5, 1, 5'd0, 0, 0, 0);
        step();
        set_issue(1, 0, 5'd0, 0, 5'd5, 0, 0, 0);
        #1 check("fp_int_separate", 32'(stall), 32'd0);
        step();
        set_issue(1, 0, 5'd0, 0, 5'd0, 0, 1, 5'd5);
        #1 check("rs3_stall", 32'(stall), 32'd1);
        set_req(1, 5'd5, 32'h3F800000, 1'b1);
        grant(3'b010, 3'b010, 1, 1);
        req_valid = '0;
        #1 check("rs3_stall_write_cycle", 32'(stall), 32'd1);
        step();
        check("rs3_released", 32'(stall), 32'd0);
        check("rf_f5", rf_fp[5], 32'h3F800000);
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);

        // Skip / wrap, rr_ptr is 2 here
        set_req(0, 5'd1, 32'h0000_1001, 1'b0);
        set_req(1, 5'd2, 32'h0000_2002, 1'b1);
        set_req(2, 5'd3, 32'h0000_3003, 1'b0);
        grant(3'b010, 3'b010, 1, 1);   // ptr stays 2
        grant(3'b101, 3'b100, 2, 1);   // ptr 2 -> 0
        grant(3'b001, 3'b001, 0, 1);   // ptr 0 -> 1
        grant(3'b101, 3'b100, 2, 1);   // ptr 1 -> 0

        // Round robin with all requesters held high
        set_req(0, 5'd10, 32'hA0A0_0000, 1'b0);
        set_req(1, 5'd11, 32'hB1B1_1111, 1'b1);
        set_req(2, 5'd12, 32'hC2C2_2222, 1'b0);
        for (int r = 0; r < 2; r++) begin
            grant(3'b111, 3'b001, 0, 1);
            grant(3'b111, 3'b010, 1, 1);
            grant(3'b111, 3'b100, 2, 1);
        end
        req_valid = '0;
        step();

        // x0 and WAW, ptr is 0
        set_issue(1, 1, 5'd0, 0, 5'd0, 0, 0, 0);
        #1 check("x0_dest_issue", 32'(stall), 32'd0);
        step();
        set_issue(1, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        #1 check("x0_reader", 32'(stall), 32'd0);
        step();
        set_issue(1, 1, 5'd7, 0, 5'd0, 0, 0, 0);
        step();
        #1 check("waw_stall", 32'(stall), 32'd1);
        set_req(0, 5'd0, 32'h1234_5678, 1'b0);
        set_req(2, 5'd7, 32'h7777_0007, 1'b0);
        grant(3'b001, 3'b001, 0, 1);   // x0 write, ptr -> 1
        req_valid = '0;
        #1 check("waw_stall_x0_wb", 32'(stall), 32'd1);
        grant(3'b100, 3'b100, 2, 1);   // x7 write, ptr -> 0
        req_valid = '0;
        #1 check("waw_stall_write_cycle", 32'(stall), 32'd1);
        step();
        check("waw_released", 32'(stall), 32'd0);
        check("rf_x7", rf_int[7], 32'h7777_0007);
        check("rf_x0", rf_int[0], 32'd0);
        step();                          // second x7 issue accepted
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a write cycle
        set_req(0, 5'd9, 32'h9999_9999, 1'b0);
        grant(3'b001, 3'b001, 0, 0);   // ptr -> 1, not expected to commit
        req_valid = '0;
        check("pre_reset_write_reg", 32'(write_reg), 32'd1);
        #1 rst_n = 1'b0;
        set_issue(1, 0, 5'd0, 0, 5'd7, 0, 0, 0);
        #1 check("reset_write_reg", 32'(write_reg), 32'd0);
        check("reset_wb_add", 32'(wb_add), 32'd0);
        check("reset_wb_data", wb_data, 32'd0);
        check("reset_busy_cleared", 32'(stall), 32'd0);
        set_issue(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        set_req(0, 5'd4, 32'h4444_0004, 1'b0);
        set_req(2, 5'd6, 32'h6666_0006, 1'b1);
        grant(3'b101, 3'b001, 0, 1);   // rr_ptr back to 0
        req_valid = '0;
        step();
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
